// File: rtl/hs_cdc_bridge_if.sv
// Valid/ready word bus with an optional response
// word returned to the source side.
interface hs_cdc_bridge_if #(
  parameter int DATA_W = 32,
  parameter int RSP_W  = 32
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic              rsp_valid;
  logic [RSP_W-1:0]  rsp_data;

  modport master (
    output valid, data,
    input  ready, rsp_data
  );

  modport slave (
    input  valid, data,
    output ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/hs_cdc_bridge.sv
// 4-phase req/ack CDC bridge, t_clk -> r_clk.
// Define HS_CDC_RSP_EN to return a response word.
module hs_cdc_bridge #(
  parameter int DATA_W      = 32,
  parameter int RSP_W       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic            t_clk,
  input  logic            t_rst_n,
  input  logic            r_clk,
  input  logic            r_rst_n,
  hs_cdc_bridge_if.slave  s,
  hs_cdc_bridge_if.master d
);

  typedef enum logic [1:0] {
    T_IDLE, T_REQ, T_DROP
  } t_state_e;

  typedef enum logic [1:0] {
    R_IDLE, R_HOLD, R_ACK
  } r_state_e;

  t_state_e          t_st, t_nxt;
  logic              req_t, req_nxt;
  logic              t_ld, t_done, t_rdy;
  logic [DATA_W-1:0] tx_data;
  logic [SYNC_STAGES-1:0] ack_sq;
  logic [SYNC_STAGES:0]   t_warm;
  logic              ack_sync;

  r_state_e          r_st, r_nxt;
  logic              ack_r, ack_nxt;
  logic              dv_q, dv_nxt;
  logic              r_cap, r_take;
  logic [DATA_W-1:0] dd_q;
  logic [SYNC_STAGES-1:0] req_sq;
  logic              req_sync;

  assign ack_sync = ack_sq[SYNC_STAGES-1];
  assign req_sync = req_sq[SYNC_STAGES-1];

  always_ff @(posedge t_clk or negedge t_rst_n) begin
    if (!t_rst_n) begin
      ack_sq  <= '0;
      t_warm  <= '0;
      t_st    <= T_IDLE;
      req_t   <= 1'b0;
      tx_data <= '0;
    end else begin
      ack_sq  <= {ack_sq[SYNC_STAGES-2:0], ack_r};
      t_warm  <= {t_warm[SYNC_STAGES-1:0], 1'b1};
      t_st    <= t_nxt;
      req_t   <= req_nxt;
      if (t_ld) tx_data <= s.data;
    end
  end

  // t_warm keeps s_ready low until the freshly reset
  // ack synchroniser again mirrors the live ack_r.
  always_comb begin
    t_nxt   = t_st;
    req_nxt = req_t;
    t_ld    = 1'b0;
    t_done  = 1'b0;
    t_rdy   = 1'b0;
    unique case (t_st)
      T_IDLE: begin
        t_rdy = t_warm[SYNC_STAGES] && !ack_sync;
        if (s.valid && t_rdy) begin
          t_ld    = 1'b1;
          req_nxt = 1'b1;
          t_nxt   = T_REQ;
        end
      end
      T_REQ: begin
        if (ack_sync) begin
          req_nxt = 1'b0;
          t_done  = 1'b1;
          t_nxt   = T_DROP;
        end
      end
      T_DROP: begin
        if (!ack_sync) t_nxt = T_IDLE;
      end
      default: begin
        req_nxt = 1'b0;
        t_nxt   = T_IDLE;
      end
    endcase
  end

  assign s.ready = t_rdy;

  always_ff @(posedge r_clk or negedge r_rst_n) begin
    if (!r_rst_n) begin
      req_sq <= '0;
      r_st   <= R_IDLE;
      ack_r  <= 1'b0;
      dv_q   <= 1'b0;
      dd_q   <= '0;
    end else begin
      req_sq <= {req_sq[SYNC_STAGES-2:0], req_t};
      r_st   <= r_nxt;
      ack_r  <= ack_nxt;
      dv_q   <= dv_nxt;
      if (r_cap) dd_q <= tx_data;
    end
  end

  always_comb begin
    r_nxt   = r_st;
    ack_nxt = ack_r;
    dv_nxt  = dv_q;
    r_cap   = 1'b0;
    r_take  = 1'b0;
    unique case (r_st)
      R_IDLE: begin
        if (req_sync) begin
          r_cap  = 1'b1;
          dv_nxt = 1'b1;
          r_nxt  = R_HOLD;
        end
      end
      R_HOLD: begin
        if (d.ready) begin
          r_take  = 1'b1;
          dv_nxt  = 1'b0;
          ack_nxt = 1'b1;
          r_nxt   = R_ACK;
        end
      end
      R_ACK: begin
        if (!req_sync) begin
          ack_nxt = 1'b0;
          r_nxt   = R_IDLE;
        end
      end
      default: begin
        dv_nxt  = 1'b0;
        ack_nxt = 1'b0;
        r_nxt   = R_IDLE;
      end
    endcase
  end

  assign d.valid = dv_q;
  assign d.data  = dd_q;

`ifdef HS_CDC_RSP_EN
  logic [RSP_W-1:0] rsp_r;
  logic [RSP_W-1:0] rsp_t;
  logic             rsp_v;

  always_ff @(posedge r_clk or negedge r_rst_n) begin
    if (!r_rst_n) rsp_r <= '0;
    else if (r_take) rsp_r <= d.rsp_data;
  end

  // rsp_r is static from ack_r rising until ack_r falls.
  always_ff @(posedge t_clk or negedge t_rst_n) begin
    if (!t_rst_n) begin
      rsp_v <= 1'b0;
      rsp_t <= '0;
    end else begin
      rsp_v <= t_done;
      if (t_done) rsp_t <= rsp_r;
    end
  end

  assign s.rsp_valid = rsp_v;
  assign s.rsp_data  = rsp_t;
`else
  logic unused_rsp;
  assign unused_rsp  = ^{d.rsp_data, r_take, t_done};
  assign s.rsp_valid = 1'b0;
  assign s.rsp_data  = '0;
`endif

endmodule
